// File: rtl/uart_tx_stream.sv
// 8N1 UART transmitter fed by a valid/ready byte stream; accepts a byte only
// while the line is idle and shifts it out LSB first at clk_frequency/baud_rate.
module uart_tx_stream #(
    parameter int clk_frequency = 50_000_000,
    parameter int baud_rate     = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up_valid,
    output logic       up_ready,
    input  logic [7:0] up_data,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);
    localparam int DIV   = clk_frequency / baud_rate;
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("uart_tx_stream: clk_frequency/baud_rate must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       idx, idx_next;
    logic [7:0]       shift, shift_next;
    logic             tx_next, ready_next, done_next;
    logic             xfer, bit_end;

    assign xfer    = up_valid && up_ready;
    assign bit_end = (cnt == LAST);
    assign busy    = (state != IDLE);

    always_comb begin
        state_next = state;
        cnt_next   = bit_end ? '0 : cnt + CNT_W'(1);
        idx_next   = idx;
        shift_next = shift;
        tx_next    = tx;
        ready_next = up_ready;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                // The counter is parked at zero so every frame starts with a full bit time.
                cnt_next   = '0;
                tx_next    = 1'b1;
                ready_next = 1'b1;
                if (xfer) begin
                    state_next = START;
                    tx_next    = 1'b0;
                    idx_next   = '0;
                    ready_next = 1'b0;
                    shift_next = up_data;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    tx_next    = shift[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx != 3'd7) begin
                        shift_next = shift >> 1;
                        tx_next    = shift[1];
                        idx_next   = idx + 3'd1;
                    end else begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_next = IDLE;
                    ready_next = 1'b1;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shift      <= '0;
            tx         <= 1'b1;
            up_ready   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            idx        <= idx_next;
            shift      <= shift_next;
            tx         <= tx_next;
            up_ready   <= ready_next;
            frame_done <= done_next;
        end
    end
endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: a DIV=4 instance checked by a serial receiver model,
// plus a default-rate instance for the full-length frame.
module tb_uart_tx_stream;
    localparam int DIV_A = 1_000_000 / 250_000;
    localparam int DIV_B = 50_000_000 / 115_200;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid_a = 1'b0;
    logic [7:0] data_a = 8'h00;
    logic       ready_a, tx_a, busy_a, done_a;
    logic       valid_b = 1'b0;
    logic [7:0] data_b = 8'h00;
    logic       ready_b, tx_b, busy_b, done_b;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int fd_cnt = 0;
    int abort_cnt = 0;

    typedef struct {
        logic [7:0] val;
        int         st;
        bit         ok;
    } frame_t;
    frame_t rx_q[$];

    uart_tx_stream #(.clk_frequency(1_000_000), .baud_rate(250_000)) dut_a (
        .clk(clk), .rst(rst), .up_valid(valid_a), .up_ready(ready_a), .up_data(data_a),
        .tx(tx_a), .busy(busy_a), .frame_done(done_a)
    );

    uart_tx_stream dut_b (
        .clk(clk), .rst(rst), .up_valid(valid_b), .up_ready(ready_b), .up_data(data_b),
        .tx(tx_b), .busy(busy_b), .frame_done(done_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst && valid_a && ready_a) hs_cnt <= hs_cnt + 1;
        if (done_a) fd_cnt <= fd_cnt + 1;
    end

    // Receiver model: frames start on a falling edge of the idle line; every bit
    // must hold one value for DIV_A consecutive cycles.
    initial begin
        logic       prev_tx;
        logic       bitv;
        logic [7:0] val;
        int         st;
        bit         ok, abort_f;
        prev_tx = 1'b1;
        forever begin
            @(negedge clk);
            if (rst && prev_tx === 1'b1 && tx_a === 1'b0) begin
                st = cyc; ok = 1'b1; abort_f = 1'b0; val = 8'h00; bitv = 1'b0;
                for (int b = 0; b < 10 && !abort_f; b++) begin
                    for (int k = 0; k < DIV_A && !abort_f; k++) begin
                        if (!(b == 0 && k == 0)) @(negedge clk);
                        if (!rst) abort_f = 1'b1;
                        if (k == 0) bitv = tx_a;
                        else if (tx_a !== bitv) ok = 1'b0;
                    end
                    if (b == 0 && bitv !== 1'b0) ok = 1'b0;
                    if (b >= 1 && b <= 8) val[b-1] = bitv;
                    if (b == 9 && bitv !== 1'b1) ok = 1'b0;
                end
                if (abort_f) abort_cnt = abort_cnt + 1;
                else rx_q.push_back('{val: val, st: st, ok: ok});
            end
            prev_tx = tx_a;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, time=%0t limit=1ms", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic frame_bit(input logic [7:0] b, input int i);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        return f[i];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int bad;
        bad = 0;
        rst = 1'b0; valid_a = 1'b1; data_a = 8'h77; valid_b = 1'b1; data_b = 8'h77;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || ready_a !== 1'b0 || busy_a !== 1'b0 || tx_b !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_hold: bad cycles got %0d expected 0", bad);
        end
        step();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_a !== 1'b0) begin
            errors++;
            $display("FAIL release_ready0: got %b expected 0", ready_a);
        end
        step();
        valid_a = 1'b0; valid_b = 1'b0;
        @(negedge clk);
        checks++;
        if ({ready_a, tx_a, busy_a, ready_b} !== 4'b1101) begin
            errors++;
            $display("FAIL release_ready1: got %b expected 1101", {ready_a, tx_a, busy_a, ready_b});
        end
        checks++;
        if (hs_cnt !== 0) begin
            errors++;
            $display("FAIL reset_no_transfer: handshakes got %0d expected 0", hs_cnt);
        end
    endtask

    task automatic test_single(input logic [7:0] b);
        localparam int N = 10 * DIV_A + 5;
        logic [N-1:0] tx_o, rdy_o, dn_o, bsy_o, tx_e, rdy_e, dn_e, bsy_e;
        int base_hs, base_q;
        base_hs = hs_cnt; base_q = rx_q.size();
        step();
        valid_a = 1'b1; data_a = b;
        step();
        valid_a = 1'b0; data_a = 8'($urandom);
        for (int n = 0; n < N; n++) begin
            @(negedge clk);
            tx_o[n] = tx_a; rdy_o[n] = ready_a; dn_o[n] = done_a; bsy_o[n] = busy_a;
            tx_e[n]  = (n < 10 * DIV_A) ? frame_bit(b, n / DIV_A) : 1'b1;
            rdy_e[n] = (n >= 10 * DIV_A);
            dn_e[n]  = (n == 10 * DIV_A);
            bsy_e[n] = (n < 10 * DIV_A);
        end
        checks++;
        if (tx_o !== tx_e) begin
            errors++;
            $display("FAIL single_tx_%h: got %h expected %h", b, tx_o, tx_e);
        end
        checks++;
        if (rdy_o !== rdy_e) begin
            errors++;
            $display("FAIL single_ready_%h: got %h expected %h", b, rdy_o, rdy_e);
        end
        checks++;
        if (dn_o !== dn_e) begin
            errors++;
            $display("FAIL single_done_%h: got %h expected %h", b, dn_o, dn_e);
        end
        checks++;
        if (bsy_o !== bsy_e) begin
            errors++;
            $display("FAIL single_busy_%h: got %h expected %h", b, bsy_o, bsy_e);
        end
        checks++;
        if (rx_q.size() !== base_q + 1) begin
            errors++;
            $display("FAIL single_frames_%h: got %0d expected %0d", b, rx_q.size(), base_q + 1);
        end else if (rx_q[base_q].val !== b || !rx_q[base_q].ok) begin
            errors++;
            $display("FAIL single_decode: got %h ok=%0d expected %h ok=1", rx_q[base_q].val, rx_q[base_q].ok, b);
        end
        checks++;
        if (hs_cnt !== base_hs + 1) begin
            errors++;
            $display("FAIL single_handshakes: got %0d expected %0d", hs_cnt - base_hs, 1);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [3];
        logic [7:0] fifo[$];
        int base_hs, base_q, k;
        bit h;
        exp_b = '{8'h00, 8'hFF, 8'h55};
        for (int i = 0; i < 3; i++) fifo.push_back(exp_b[i]);
        base_hs = hs_cnt; base_q = rx_q.size();
        step();
        valid_a = 1'b1; data_a = fifo[0];
        for (k = 0; k < 200 && fifo.size() > 0; k++) begin
            @(negedge clk);
            h = ready_a;
            step();
            if (h) void'(fifo.pop_front());
            valid_a = (fifo.size() > 0);
            if (fifo.size() > 0) data_a = fifo[0];
        end
        for (int w = 0; w < 100 && rx_q.size() < base_q + 3; w++) @(negedge clk);
        checks++;
        if (rx_q.size() !== base_q + 3) begin
            errors++;
            $display("FAIL b2b_frames: got %0d expected %0d", rx_q.size() - base_q, 3);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rx_q[base_q + i].val !== exp_b[i] || !rx_q[base_q + i].ok) begin
                    errors++;
                    $display("FAIL b2b_decode_%0d: got %h ok=%0d expected %h ok=1", i,
                             rx_q[base_q + i].val, rx_q[base_q + i].ok, exp_b[i]);
                end
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (rx_q[base_q + i].st - rx_q[base_q + i - 1].st !== 10 * DIV_A + 1) begin
                    errors++;
                    $display("FAIL b2b_spacing_%0d: got %0d expected %0d", i,
                             rx_q[base_q + i].st - rx_q[base_q + i - 1].st, 10 * DIV_A + 1);
                end
            end
        end
        checks++;
        if (hs_cnt - base_hs !== 3) begin
            errors++;
            $display("FAIL b2b_handshakes: got %0d expected 3", hs_cnt - base_hs);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] b0, captured;
        int base_hs, base_q;
        bit got;
        got = 1'b0; captured = 8'h00;
        base_hs = hs_cnt; base_q = rx_q.size();
        b0 = 8'($urandom);
        step();
        valid_a = 1'b1; data_a = b0;
        step();
        data_a = 8'h3C;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (ready_a) begin
                captured = data_a;
                got = 1'b1;
            end
            step();
            if (got) valid_a = 1'b0;
            data_a = 8'($urandom);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL bp_ready_timeout: got ready=0 expected 1 within 100 cycles");
        end
        for (int w = 0; w < 100 && rx_q.size() < base_q + 2; w++) @(negedge clk);
        repeat (20) @(negedge clk);
        checks++;
        if (rx_q.size() !== base_q + 2) begin
            errors++;
            $display("FAIL bp_frames: got %0d expected 2", rx_q.size() - base_q);
        end else if (rx_q[base_q].val !== b0 || rx_q[base_q + 1].val !== captured
                     || !rx_q[base_q].ok || !rx_q[base_q + 1].ok) begin
            errors++;
            $display("FAIL bp_decode: got %h %h expected %h %h", rx_q[base_q].val,
                     rx_q[base_q + 1].val, b0, captured);
        end
        checks++;
        if (hs_cnt - base_hs !== 2) begin
            errors++;
            $display("FAIL bp_handshakes: got %0d expected 2", hs_cnt - base_hs);
        end
    endtask

    task automatic test_reset_mid();
        int base_fd, base_ab, base_q;
        base_fd = fd_cnt; base_ab = abort_cnt; base_q = rx_q.size();
        step();
        valid_a = 1'b1; data_a = 8'h81;
        step();
        valid_a = 1'b0;
        repeat (17) step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_a !== 1'b0) begin
            errors++;
            $display("FAIL mid_before_reset_tx: got %b expected 0", tx_a);
        end
        @(negedge clk);
        checks++;
        if ({tx_a, busy_a, done_a, ready_a} !== 4'b1000) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %b expected 1000", {tx_a, busy_a, done_a, ready_a});
        end
        step();
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if (fd_cnt !== base_fd || abort_cnt !== base_ab + 1 || rx_q.size() !== base_q) begin
            errors++;
            $display("FAIL mid_abandon: got done=%0d aborts=%0d frames=%0d expected 0 1 0",
                     fd_cnt - base_fd, abort_cnt - base_ab, rx_q.size() - base_q);
        end
        test_single(8'h42);
    endtask

    task automatic test_defaults();
        int mism;
        logic [7:0] dec;
        mism = 0; dec = 8'h00;
        step();
        valid_b = 1'b1; data_b = 8'h0D;
        step();
        valid_b = 1'b0;
        for (int n = 0; n < 10 * DIV_B; n++) begin
            @(negedge clk);
            if (tx_b !== frame_bit(8'h0D, n / DIV_B) || ready_b !== 1'b0 || done_b !== 1'b0) mism++;
            if (n % DIV_B == DIV_B / 2 && n / DIV_B >= 1 && n / DIV_B <= 8) dec[n / DIV_B - 1] = tx_b;
        end
        checks++;
        if (mism !== 0) begin
            errors++;
            $display("FAIL default_bit_timing: bad cycles got %0d expected 0", mism);
        end
        checks++;
        if (dec !== 8'h0D) begin
            errors++;
            $display("FAIL default_decode: got %h expected 0d", dec);
        end
        @(negedge clk);
        checks++;
        if ({done_b, ready_b, busy_b, tx_b} !== 4'b1101) begin
            errors++;
            $display("FAIL default_frame_end: got %b expected 1101", {done_b, ready_b, busy_b, tx_b});
        end
    endtask

    initial begin
        test_reset();
        test_single(8'hA5);
        test_single(8'($urandom));
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_defaults();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
